ram_dp_be: RTL and testbench

Parametrised simple dual-port synchronous RAM, successor to the basic single-clock RAM block: independent write and read ports with per-byte write enables and a selectable 1- or 2-cycle read pipeline. A read-valid strobe marks returned data. A post-reset hardware clear sweep zeroes the array before any access. It is the standard on-chip buffer for datapath blocks that need partial-word updates and a deterministic memory state after reset.

---
 rtl/ram_dp_be.sv | 187 ++++++++++++++++++
 tb/tb_ram_dp_be.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// Simple dual-port RAM with byte enables, post-reset zeroing sweep and 1/2-cycle read pipeline.
// Define RAM_PARITY_EN to add per-byte even parity with injection (par_inj) and a parity_err flag.
module ram_dp_be #(
    parameter int MEM_WIDTH  = 16,
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_SIZE  = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [MEM_WIDTH-1:0]   din,
    input  logic [MEM_WIDTH/8-1:0] byte_en,
    input  logic [ADDR_SIZE-1:0]   addr_wr,
    input  logic [ADDR_SIZE-1:0]   addr_rd,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic                   blk_select,
`ifdef RAM_PARITY_EN
    input  logic                   par_inj,
    output logic                   parity_err,
`endif
    output logic [MEM_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic                   busy
);

    localparam int NB = MEM_WIDTH / 8;
    localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ADDR_SIZE-1:0]   r_clr_cnt;
    logic [ADDR_SIZE-1:0]   w_clr_cnt_next;
    logic                   w_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_busy         = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy = 1'b1;
                if (r_clr_cnt == LAST_ADDR) begin
                    w_state_next   = S_READY;
                    w_clr_cnt_next = '0;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign busy = w_busy;

    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_acc;
    logic w_rd_acc;

    assign w_wr_in_range = ({1'b0, addr_wr} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, addr_rd} < DEPTH_EXT);
    assign w_wr_acc      = !w_busy && blk_select && wr_en && w_wr_in_range;
    assign w_rd_acc      = !w_busy && blk_select && rd_en;

    // The sweep borrows the write port: all bytes enabled, zero data, clr_cnt as address.
    logic [NB-1:0]        w_mem_we;
    logic [ADDR_SIZE-1:0] w_mem_addr;
    logic [MEM_WIDTH-1:0] w_mem_din;

    assign w_mem_we   = w_busy ? {NB{1'b1}} : (w_wr_acc ? byte_en : '0);
    assign w_mem_addr = w_busy ? r_clr_cnt : addr_wr;
    assign w_mem_din  = w_busy ? '0 : din;

    logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [MEM_WIDTH-1:0] w_rd_word;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] r_par [MEM_DEPTH];
    logic [NB-1:0] w_par_din;
    logic [NB-1:0] w_rd_par;
    logic [NB-1:0] w_rd_calc;
    logic          w_par_bad;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_par
            assign w_par_din[gi] = (^w_mem_din[8*gi +: 8]) ^ (w_wr_acc & par_inj);
            assign w_rd_calc[gi] = ^w_rd_word[8*gi +: 8];
        end
    endgenerate

    assign w_rd_par  = w_rd_in_range ? r_par[addr_rd] : '0;
    assign w_par_bad = |(w_rd_calc ^ w_rd_par);
`endif

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (w_mem_we[i]) begin
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_din[8*i +: 8];
`ifdef RAM_PARITY_EN
                r_par[w_mem_addr][i] <= w_par_din[i];
`endif
            end
        end
    end

    // Sampled before the write lands at the same edge, giving read-first collisions.
    assign w_rd_word = w_rd_in_range ? r_mem[addr_rd] : '0;

    logic [MEM_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic                 r_rd_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_perr  <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
            end
`ifdef RAM_PARITY_EN
            r_rd_perr <= w_rd_acc && w_rd_in_range && w_par_bad;
`else
            r_rd_perr <= 1'b0;
`endif
        end
    end

    logic w_out_perr;

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [MEM_WIDTH-1:0] r_out_data;
            logic                 r_out_valid;
            logic                 r_out_perr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                    r_out_perr  <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_valid;
                    r_out_perr  <= r_rd_valid && r_rd_perr;
                    if (r_rd_valid) begin
                        r_out_data <= r_rd_data;
                    end
                end
            end

            assign dout       = r_out_data;
            assign dout_valid = r_out_valid;
            assign w_out_perr = r_out_perr;
        end else begin : g_lat1
            assign dout       = r_rd_data;
            assign dout_valid = r_rd_valid;
            assign w_out_perr = r_rd_perr;
        end
    endgenerate

`ifdef RAM_PARITY_EN
    assign parity_err = w_out_perr;
`else
    logic w_unused_perr;
    assign w_unused_perr = w_out_perr;
`endif

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: a 16-word latency-1 instance and a 1000-word latency-2 instance share stimulus.
module tb_ram_dp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic [1:0]  be;
    logic [9:0]  wa;
    logic [9:0]  ra;
    logic        wr;
    logic        rd;
    logic        blk;
    logic [15:0] a_dout, b_dout;
    logic        a_dv, b_dv, a_busy, b_busy;
`ifdef RAM_PARITY_EN
    logic        pinj;
    logic        a_perr, b_perr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_dp_be #(.MEM_WIDTH(16), .MEM_DEPTH(16), .ADDR_SIZE(5), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst(rst), .din(din), .byte_en(be), .addr_wr(wa[4:0]), .addr_rd(ra[4:0]),
        .wr_en(wr), .rd_en(rd), .blk_select(blk),
`ifdef RAM_PARITY_EN
        .par_inj(pinj), .parity_err(a_perr),
`endif
        .dout(a_dout), .dout_valid(a_dv), .busy(a_busy)
    );

    ram_dp_be #(.MEM_WIDTH(16), .MEM_DEPTH(1000), .ADDR_SIZE(10), .RD_LATENCY(2)) u_b (
        .clk(clk), .rst(rst), .din(din), .byte_en(be), .addr_wr(wa), .addr_rd(ra),
        .wr_en(wr), .rd_en(rd), .blk_select(blk),
`ifdef RAM_PARITY_EN
        .par_inj(pinj), .parity_err(b_perr),
`endif
        .dout(b_dout), .dout_valid(b_dv), .busy(b_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: memory contents, cycles since reset release, expected output stream.
    logic [15:0] m_a [16];
    logic [15:0] m_b [1000];
    int          cnt_a, cnt_b;
    logic        a_rdy, b_rdy;
    logic        ea_v, eb1_v, eb_v;
    logic [15:0] ea_d, eb1_d, eb_d;

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] b);
        logic [15:0] r;
        r = o;
        if (b[0]) r[7:0]  = n[7:0];
        if (b[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a = 0; cnt_b = 0;
            ea_v = 1'b0; ea_d = '0;
            eb1_v = 1'b0; eb1_d = '0; eb_v = 1'b0; eb_d = '0;
            foreach (m_a[i]) m_a[i] = '0;
            foreach (m_b[i]) m_b[i] = '0;
        end else begin
            a_rdy = (cnt_a >= 16);
            b_rdy = (cnt_b >= 1000);
            ea_v = a_rdy && blk && rd;
            if (ea_v) ea_d = (ra[4:0] < 16) ? m_a[ra[4:0]] : 16'h0;
            if (a_rdy && blk && wr && wa[4:0] < 16) m_a[wa[4:0]] = merge(m_a[wa[4:0]], din, be);
            eb_v = eb1_v;
            if (eb1_v) eb_d = eb1_d;
            eb1_v = b_rdy && blk && rd;
            if (eb1_v) eb1_d = (ra < 1000) ? m_b[ra] : 16'h0;
            if (b_rdy && blk && wr && wa < 1000) m_b[wa] = merge(m_b[wa], din, be);
            if (cnt_a < 16) cnt_a++;
            if (cnt_b < 1000) cnt_b++;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("a_busy", a_busy, cnt_a < 16);
        chk("b_busy", b_busy, cnt_b < 1000);
        chk("a_valid", a_dv, ea_v);
        chk("b_valid", b_dv, eb_v);
        chk("a_dout", a_dout, ea_d);
        chk("b_dout", b_dout, eb_d);
    end

    task automatic op(input logic w, input logic r, input logic [9:0] aw, input logic [9:0] ar,
                      input logic [15:0] d, input logic [1:0] b);
        @(negedge clk);
        wr = w; rd = r; wa = aw; ra = ar; din = d; be = b;
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string nm, input logic dv, input logic [15:0] d, input logic [15:0] exp);
        chk({nm, "_valid"}, dv, 1'b1);
        chk(nm, d, exp);
    endtask

    task automatic count_busy(output int na, output int nb);
        int guard;
        na = 0; nb = 0; guard = 0;
        while ((a_busy || b_busy) && guard < 1100) begin
            if (a_busy) na++;
            if (b_busy) nb++;
            if (!a_busy) begin
                wr = 1'b0; rd = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        wr = 1'b0; rd = 1'b0;
        chk("sweep_bounded", guard < 1100, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb;
        rst = 1'b1; blk = 1'b1; wr = 1'b0; rd = 1'b0;
        wa = '0; ra = '0; din = '0; be = '0;
`ifdef RAM_PARITY_EN
        pinj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_a_busy", a_busy, 1'b1);
        chk("rst_b_busy", b_busy, 1'b1);
        chk("rst_a_valid", a_dv, 1'b0);
        chk("rst_b_dout", b_dout, 16'h0);

        // Accesses held on during the sweep must be ignored.
        wr = 1'b1; rd = 1'b1; wa = 10'd5; ra = 10'd5; din = 16'hFFFF; be = 2'b11;
        rst = 1'b0;
        count_busy(na, nb);
        chk("sweep_len_a", na, 16);
        chk("sweep_len_b", nb, 1000);
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 10'd0, 10'(i), 16'h0, 2'b00);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);
        op(1'b0, 1'b1, 10'd0, 10'd5, 16'h0, 2'b00);
        rdchk("clr_a5", a_dv, a_dout, 16'h0000);

        // Byte enables
        op(1'b1, 1'b0, 10'd5, 10'd0, 16'hA5C3, 2'b11);
        op(1'b1, 1'b0, 10'd5, 10'd0, 16'h1200, 2'b10);
        op(1'b0, 1'b1, 10'd0, 10'd5, 16'h0, 2'b00);
        rdchk("be_a", a_dv, a_dout, 16'h12C3);
        chk("be_b_early", b_dv, 1'b0);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);
        rdchk("be_b", b_dv, b_dout, 16'h12C3);

        // Read-first collision, pipelined back-to-back
        op(1'b1, 1'b0, 10'd7, 10'd0, 16'h0001, 2'b11);
        op(1'b1, 1'b1, 10'd7, 10'd7, 16'hBEEF, 2'b11);
        rdchk("col_a", a_dv, a_dout, 16'h0001);
        op(1'b0, 1'b1, 10'd0, 10'd7, 16'h0, 2'b00);
        rdchk("col2_a", a_dv, a_dout, 16'hBEEF);
        rdchk("col_b", b_dv, b_dout, 16'h0001);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);
        rdchk("col2_b", b_dv, b_dout, 16'hBEEF);

        // Boundaries: 999 last word of B, 1000 out of range; A sees low 5 bits
        op(1'b1, 1'b0, 10'd999, 10'd0, 16'h3999, 2'b11);
        op(1'b1, 1'b0, 10'd1000, 10'd0, 16'hDEAD, 2'b11);
        op(1'b0, 1'b1, 10'd0, 10'd999, 16'h0, 2'b00);
        op(1'b0, 1'b1, 10'd0, 10'd1000, 16'h0, 2'b00);
        rdchk("bnd999_b", b_dv, b_dout, 16'h3999);
        op(1'b0, 1'b1, 10'd0, 10'd998, 16'h0, 2'b00);
        rdchk("bnd1000_b", b_dv, b_dout, 16'h0000);
        op(1'b1, 1'b0, 10'd20, 10'd0, 16'hCAFE, 2'b11);
        op(1'b0, 1'b1, 10'd0, 10'd20, 16'h0, 2'b00);
        rdchk("oor_a", a_dv, a_dout, 16'h0000);
        op(1'b0, 1'b1, 10'd0, 10'd4, 16'h0, 2'b00);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);

        // blk_select low gates both ports
        blk = 1'b0;
        op(1'b1, 1'b1, 10'd3, 10'd3, 16'h1111, 2'b11);
        chk("blk_a_valid", a_dv, 1'b0);
        blk = 1'b1;
        op(1'b0, 1'b1, 10'd0, 10'd3, 16'h0, 2'b00);
        rdchk("blk_a_read", a_dv, a_dout, 16'h0000);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);

`ifdef RAM_PARITY_EN
        pinj = 1'b1;
        op(1'b1, 1'b0, 10'd3, 10'd0, 16'h00FF, 2'b11);
        pinj = 1'b0;
        op(1'b1, 1'b0, 10'd4, 10'd0, 16'h00FF, 2'b11);
        op(1'b0, 1'b1, 10'd0, 10'd3, 16'h0, 2'b00);
        chk("par_a3", a_perr, 1'b1);
        op(1'b0, 1'b1, 10'd0, 10'd4, 16'h0, 2'b00);
        chk("par_a4", a_perr, 1'b0);
        chk("par_b3", b_perr, 1'b1);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);
        chk("par_b4", b_perr, 1'b0);
`endif

        // Reset during a latency-2 read burst
        repeat (3) op(1'b0, 1'b1, 10'd0, 10'd999, 16'h0, 2'b00);
        rdchk("pre_rst_b", b_dv, b_dout, 16'h3999);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_b_dout", b_dout, 16'h0);
        chk("arst_b_valid", b_dv, 1'b0);
        chk("arst_a_dout", a_dout, 16'h0);
        chk("arst_a_valid", a_dv, 1'b0);
        repeat (2) @(negedge clk);
        rd = 1'b0;
        rst = 1'b0;

        // Reset in the middle of the sweep restarts it
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(na, nb);
        chk("resweep_len_a", na, 16);
        chk("resweep_len_b", nb, 1000);
        op(1'b0, 1'b1, 10'd0, 10'd5, 16'h0, 2'b00);
        rdchk("post_a5", a_dv, a_dout, 16'h0000);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);
        rdchk("post_b5", b_dv, b_dout, 16'h0000);
        op(1'b0, 1'b0, 10'd0, 10'd0, 16'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
